// File: rtl/spi_send_con.sv
// spi_send_con -- multi-line SPI-style transmitter.
//
// Accepts a DATA_WIDTH word on a single-cycle trigger, pulls chip select low
// and shifts the word out MSB-first, LINES bits per beat, with a self-generated
// data clock of DATA_CLK_PERIOD system cycles. The data clock is low for the
// first HALF cycles of each beat and high for the last HALF, so the receiver's
// rising-edge sample sits in the middle of a stable beat.
//
// Optional feature (compile-time macro): SPI_SEND_BURST_EN
//   When defined, a trigger in the last cycle of a word starts the next word
//   immediately, with chip select held low and no gap between words.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   data_in       word to send, sampled in the accept cycle only
//   trigger_in    send request, accepted when ready_out=1
//   ready_out     block can accept a trigger this cycle (decoded from state)
//   busy_out      a word is in flight
//   done_out      one-cycle pulse after the last beat of a word completes
//   data_out      data lines, data_out[LINES-1] is the beat MSB; 0 when idle
//   data_clk_out  data clock, idles low
//   sel_out       chip select, active low, idles high
module spi_send_con #(
  parameter int DATA_WIDTH      = 8,
  parameter int LINES           = 4,
  parameter int DATA_CLK_PERIOD = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [LINES-1:0]      data_out,
  output logic                  data_clk_out,
  output logic                  sel_out
);

  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int HALF  = DATA_CLK_PERIOD / 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(DATA_CLK_PERIOD);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(DATA_CLK_PERIOD - 1);
  localparam logic [CW-1:0] CLK_HALF  = CW'(HALF);

  if ((LINES < 1) || (DATA_WIDTH < LINES) || ((DATA_WIDTH % LINES) != 0) ||
      (DATA_CLK_PERIOD < 2) || ((DATA_CLK_PERIOD % 2) != 0)) begin : g_bad_params
    $error("spi_send_con: illegal parameter combination");
  end

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         beat_cnt;
  logic [CW-1:0]         clk_cnt;

  logic                  last_beat;
  logic                  last_clk;
  logic [CW-1:0]         clk_nxt;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  assign last_beat = (beat_cnt == BEAT_LAST);
  assign last_clk  = (clk_cnt == CLK_LAST);
  assign clk_nxt   = clk_cnt + CW'(1);
  assign shreg_nxt = shreg << LINES;

`ifdef SPI_SEND_BURST_EN
  assign ready_out = (state == IDLE) || ((state == SEND) && last_beat && last_clk);
`else
  assign ready_out = (state == IDLE);
`endif

  // All pin outputs are registered: each branch loads the value the pins
  // must show in the cycle that follows the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      shreg        <= '0;
      beat_cnt     <= '0;
      clk_cnt      <= '0;
      sel_out      <= 1'b1;
      data_clk_out <= 1'b0;
      data_out     <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger_in) begin
            state        <= SEND;
            shreg        <= data_in;
            beat_cnt     <= '0;
            clk_cnt      <= '0;
            sel_out      <= 1'b0;
            busy_out     <= 1'b1;
            data_clk_out <= 1'b0;
            data_out     <= data_in[DATA_WIDTH-1 -: LINES];
          end
        end
        SEND: begin
          if (!last_clk) begin
            clk_cnt      <= clk_nxt;
            data_clk_out <= (clk_nxt >= CLK_HALF);
          end else if (!last_beat) begin
            // Beat boundary: clock drops and the next beat appears together,
            // so data only moves while the clock is low.
            shreg        <= shreg_nxt;
            beat_cnt     <= beat_cnt + BW'(1);
            clk_cnt      <= '0;
            data_clk_out <= 1'b0;
            data_out     <= shreg_nxt[DATA_WIDTH-1 -: LINES];
          end else begin
            done_out <= 1'b1;
`ifdef SPI_SEND_BURST_EN
            if (trigger_in) begin
              // Chain straight into the next word; select stays low.
              shreg        <= data_in;
              beat_cnt     <= '0;
              clk_cnt      <= '0;
              data_clk_out <= 1'b0;
              data_out     <= data_in[DATA_WIDTH-1 -: LINES];
            end else
`endif
            begin
              state        <= IDLE;
              shreg        <= '0;
              beat_cnt     <= '0;
              clk_cnt      <= '0;
              sel_out      <= 1'b1;
              busy_out     <= 1'b0;
              data_clk_out <= 1'b0;
              data_out     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_send_con.md
# spi_send_con

Multi-line SPI-style transmitter: the sending end of the link consumed by `spi_receive_con`. It accepts a parallel word on a single-cycle trigger, drives chip-select active low, and shifts the word out MSB-first over `LINES` parallel data lines. It generates its own data clock at `clk_in / DATA_CLK_PERIOD`. It sits on the source board or in a loopback bench and drives the `cipo`/`dclk`/`cs` pins of the receiving design.

## Interface
- `DATA_WIDTH`, default 8: bits per word; must be a multiple of `LINES`.
- `LINES`, default 4: parallel data lines.
- `DATA_CLK_PERIOD`, default 6: `clk_in` cycles per data-clock period; even, ≥2.
- Derived: `BEATS = DATA_WIDTH/LINES`, `HALF = DATA_CLK_PERIOD/2`.
- Illegal parameter combinations stop elaboration with `$error`.

Ports:
- `clk_in` input 1: system clock. One clock domain only.
- `rst_in` input 1: reset, synchronous, active-high.
- `data_in` input DATA_WIDTH: word to send; sampled only in the accept cycle.
- `trigger_in` input 1: request to send `data_in`; accepted when `ready_out`=1.
- `ready_out` output 1: block can accept `trigger_in` this cycle.
- `busy_out` output 1: a word is in flight (`sel_out`=0).
- `done_out` output 1: one-cycle pulse when a word's last beat completes.
- `data_out` output LINES: data lines; `data_out[LINES-1]` carries the most significant bit of each beat.
- `data_clk_out` output 1: data clock; idles low. The receiver samples on its rising edge.
- `sel_out` output 1: chip select, active low; idles high.

## Operation
- FSM states:
  - IDLE: `ready_out`=1, `sel_out`=1, `data_clk_out`=0, `busy_out`=0.
  - SEND: counters are `beat_cnt` (0..BEATS-1) and `clk_cnt` (0..DATA_CLK_PERIOD-1).
- IDLE→SEND on `trigger_in`&`ready_out`:
  - Latch `data_in` into the shift register.
  - Set `beat_cnt`=0 and `clk_cnt`=0.
- In SEND:
  - `data_out` = `shreg[DATA_WIDTH-1 -: LINES]`.
  - `data_clk_out` = (`clk_cnt` ≥ HALF).
  - `sel_out`=0 and `busy_out`=1.
- `clk_cnt` increments every cycle and wraps at DATA_CLK_PERIOD-1. On wrap:
  - The shift register shifts left by `LINES`, zero-filled.
  - `beat_cnt` increments.
  - Data therefore changes only while `data_clk_out` is low, giving HALF cycles of setup and HALF cycles of hold around each rising edge.
- At wrap of the final beat (`beat_cnt`=BEATS-1), go to IDLE. The next cycle has `done_out`=1 and `sel_out`=1.
- `trigger_in` while not ready is ignored; no queueing.
- A trigger in the same cycle as `done_out` is accepted, because that cycle is IDLE. This leaves a minimum `sel_out`-high gap of 1 cycle.
- Reset (any state, including mid-word) takes effect the next cycle:
  - State goes to IDLE.
  - Outputs go to `sel_out`=1, `data_clk_out`=0, `data_out`=0, `busy_out`=0, `done_out`=0, `ready_out`=1.
  - The shift register and counters clear.
  - The partially sent word is dropped; no `done_out` pulse.
- In IDLE, `data_out` is held at 0.

## Timing
- Trigger accepted at cycle T:
  - Cycles T+1 through T+BEATS·DATA_CLK_PERIOD: `sel_out`=0, `busy_out`=1.
  - Cycle T+1+BEATS·DATA_CLK_PERIOD: `done_out`=1, `sel_out`=1.
- Beat k is driven on `data_out` during cycles T+1+k·DATA_CLK_PERIOD through T+(k+1)·DATA_CLK_PERIOD.
  - Its rising clock edge is at cycle T+1+k·DATA_CLK_PERIOD+HALF.
- With defaults (8/4/6): 12 cycles with `sel_out` low, 2 beats, 2 rising edges.
- Outputs are registered, with no combinational path from inputs to outputs. The one exception is `ready_out`, which is a function of state only.

## Configuration
- `SPI_SEND_BURST_EN` defined:
  - `ready_out` is also 1 in the final SEND cycle (`beat_cnt`=BEATS-1, `clk_cnt`=DATA_CLK_PERIOD-1).
  - A trigger in that cycle latches the new word. The next cycle starts beat 0 with `sel_out` held low and `clk_cnt`=0, so there is no gap.
  - `done_out` still pulses once for the completed word, in the first cycle of the new word.
- Undefined: `ready_out` is 1 only in IDLE. Every word is framed by its own `sel_out` low period.

## Test plan
- Reset, then idle 20 cycles -> `sel_out`=1, `data_clk_out`=0, `data_out`=0, `ready_out`=1, `busy_out`=0, `done_out`=0 throughout.
- Defaults, send 0xA5 -> `data_out`=4'hA on the first rising edge and 4'h5 on the second; `sel_out` low exactly 12 cycles; `done_out` a single pulse at T+13.
- Pulse `trigger_in` with 0x3C while busy, and change `data_in` mid-word -> ignored; word on the wire unchanged.
- Trigger 0xFF, then assert `rst_in` at T+5 -> at T+6 `sel_out`=1, `data_clk_out`=0, no `done_out`; an immediately following 0x12 sends 4'h1, 4'h2.
- Loopback into `spi_receive_con` (8/4/6) with 0x00, 0xFF, 0x81 back-to-back -> receiver reports exactly those three words in order, one `data_valid_out` each.
- With `SPI_SEND_BURST_EN`, trigger in the last cycle with 0x5A -> `sel_out` stays low for 24 cycles total and the wire carries 4'hA, 4'h5, 4'h5, 4'hA; without the macro the same trigger is ignored.
